// File: rtl/systolic_pe.sv
// Output-stationary systolic MAC processing element with a per-row drain chain.
// Latency: operands forwarded east/south in 1 cycle; own result on c_out 1 cycle after drain rises.
// Backpressure: none; valid-qualified streaming, drain is a level held for N cycles per N-PE row.
module systolic_pe #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 20,
   parameter int SIGNED   = 1,
   parameter int SATURATE = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] a_in,
   input  logic              a_valid_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              b_valid_in,
   output logic [DATA_W-1:0] a_out,
   output logic              a_valid_out,
   output logic [DATA_W-1:0] b_out,
   output logic              b_valid_out,
   input  logic              clear,
   input  logic              drain,
   input  logic [ACC_W-1:0]  c_in,
   input  logic              c_in_valid,
   input  logic              c_in_ovf,
   output logic [ACC_W-1:0]  c_out,
   output logic              c_out_valid,
   output logic              c_out_ovf,
   output logic [ACC_W-1:0]  acc
);

   localparam int PW  = 2 * DATA_W;
   localparam int EW  = ACC_W + 1;
   localparam bit SX  = (SIGNED != 0);
   localparam bit SAT = (SATURATE != 0);

   typedef enum logic {
      ACCUM = 1'b0,
      PASS  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              own_load;
   logic              in_pass;
   logic              mac_en;
   logic              clr_en;
   logic              ovf;

   logic [PW-1:0]     a_x;
   logic [PW-1:0]     b_x;
   logic [PW-1:0]     prod;
   logic [EW-1:0]     prod_x;
   logic [EW-1:0]     acc_x;
   logic [EW-1:0]     sum;
   logic              sum_ovf;
   logic [ACC_W-1:0]  sat_val;
   logic [ACC_W-1:0]  acc_mac;

   // Multiply-accumulate datapath: operands are extended to the product width so one
   // unsigned multiplier gives the correct low bits for both signed and unsigned modes;
   // one guard bit above ACC_W exposes overflow. clear substitutes zero for the old acc.
   always_comb begin
      a_x    = {{DATA_W{SX & a_in[DATA_W-1]}}, a_in};
      b_x    = {{DATA_W{SX & b_in[DATA_W-1]}}, b_in};
      prod   = a_x * b_x;
      prod_x = {{(EW-PW){SX & prod[PW-1]}}, prod};
      acc_x  = clr_en ? '0 : {SX & acc[ACC_W-1], acc};
      sum    = acc_x + prod_x;
      if (SX) begin
         sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
         sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         sum_ovf = sum[ACC_W];
         sat_val = '1;
      end
      acc_mac = (sum_ovf && SAT) ? sat_val : sum[ACC_W-1:0];
   end

   // Next-state and per-cycle control: drain wins over clear and MAC in ACCUM.
   always_comb begin
      state_nxt = state;
      own_load  = 1'b0;
      in_pass   = 1'b0;
      mac_en    = 1'b0;
      clr_en    = 1'b0;
      case (state)
         ACCUM: begin
            if (drain) begin
               own_load  = 1'b1;
               state_nxt = PASS;
            end else begin
               mac_en = a_valid_in & b_valid_in;
               clr_en = clear;
            end
         end
         PASS: begin
            in_pass = 1'b1;
            if (!drain) begin
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Operand forwarding east and south; data holds when its qualifier is low.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_out       <= '0;
         a_valid_out <= 1'b0;
         b_out       <= '0;
         b_valid_out <= 1'b0;
      end else begin
         a_valid_out <= a_valid_in;
         b_valid_out <= b_valid_in;
         if (a_valid_in) a_out <= a_in;
         if (b_valid_in) b_out <= b_in;
      end
   end

   // Accumulator, sticky overflow and drain chain: own result is launched on the first
   // drain cycle, then upstream results ripple through until drain drops.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc         <= '0;
         ovf         <= 1'b0;
         c_out       <= '0;
         c_out_valid <= 1'b0;
         c_out_ovf   <= 1'b0;
      end else if (own_load) begin
         c_out       <= acc;
         c_out_ovf   <= ovf;
         c_out_valid <= 1'b1;
         acc         <= '0;
         ovf         <= 1'b0;
      end else if (in_pass) begin
         c_out       <= c_in;
         c_out_ovf   <= c_in_ovf;
         c_out_valid <= c_in_valid & drain;
      end else begin
         c_out_valid <= 1'b0;
         if (mac_en) begin
            acc <= acc_mac;
            ovf <= (ovf & ~clr_en) | sum_ovf;
         end else if (clr_en) begin
            acc <= '0;
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
Parametrised processing element for the output-stationary systolic MAC array. It is the successor to the fixed 8-bit element.
- Forwards A operands east and B operands south, each with a valid qualifier.
- Accumulates signed or unsigned products locally, with optional saturation and a sticky overflow flag.
- Unloads its result through a per-row drain chain, so an N-PE row drains in N+1 cycles without a global read mux.

Parameters:
DATA_W, 8, operand width (a, b)
ACC_W, 20, accumulator width; must be >= 2*DATA_W
SIGNED, 1, 1 = two's-complement operands and accumulator; 0 = unsigned
SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
a_in  in  DATA_W  A operand from west
a_valid_in  in  1  a_in qualifier
b_in  in  DATA_W  B operand from north
b_valid_in  in  1  b_in qualifier
a_out  out  DATA_W  registered A to east
a_valid_out  out  1  registered a_valid_in
b_out  out  DATA_W  registered B to south
b_valid_out  out  1  registered b_valid_in
clear  in  1  start new accumulation
drain  in  1  level; row-wide unload request
c_in  in  ACC_W  drain chain data from upstream PE
c_in_valid  in  1  c_in qualifier
c_in_ovf  in  1  upstream overflow flag
c_out  out  ACC_W  drain chain data downstream
c_out_valid  out  1  c_out qualifier
c_out_ovf  out  1  overflow flag travelling with c_out
acc  out  ACC_W  live accumulator (debug/observation)

Behaviour:
- Reset (synchronous, highest priority):
  - All outputs, acc and ovf go to 0; state goes to ACCUM.
  - Reset in mid-drain aborts the drain: c_out_valid = 0 on the next cycle.
- Forwarding, every cycle in all states:
  - a_valid_out <= a_valid_in and b_valid_out <= b_valid_in.
  - a_out loads a_in only when a_valid_in = 1, else holds. Same rule for b_out. Latency is 1 cycle.
- MAC fire condition: state = ACCUM, drain = 0, a_valid_in = 1 and b_valid_in = 1. If only one operand is valid, acc is unchanged.
- Product:
  - Width is 2*DATA_W.
  - It is sign-extended (SIGNED = 1) or zero-extended (SIGNED = 0) to ACC_W+1, then added to the extended acc.
- Overflow:
  - Overflow means the sum is outside the ACC_W range (signed or unsigned as configured).
  - On overflow, internal ovf is set sticky.
  - SATURATE = 1: acc <= max or min representable value. SATURATE = 0: acc <= low ACC_W bits.
- clear (state ACCUM, drain = 0):
  - acc <= 0 and ovf <= 0.
  - If the MAC also fires that cycle, acc <= extended product, with ovf from that product alone.
- State machine:
  - ACCUM:
    - If drain = 1: c_out <= acc, c_out_ovf <= ovf, c_out_valid <= 1, acc <= 0, ovf <= 0, then go to PASS.
    - clear and MAC are both suppressed that cycle (drain wins).
    - Otherwise c_out_valid <= 0.
  - PASS:
    - Each cycle: c_out <= c_in, c_out_ovf <= c_in_ovf, c_out_valid <= c_in_valid.
    - MAC and clear are ignored; operands are still forwarded.
    - If drain = 0: c_out_valid <= 0, then go to ACCUM.
- Drain timing:
  - Own result appears 1 cycle after drain rises.
  - Upstream results follow back-to-back.
  - A row of N PEs needs drain held N cycles.
- acc port reflects the accumulator register directly.

Test Plan:
1. Assert reset 2 cycles, then release -> all outputs 0. Then drive a_in=5, a_valid_in=1 -> a_out=5, a_valid_out=1 one cycle later; acc stays 0 because b is not valid.
2. Defaults. Apply valid pairs (3,4), (-2,5), (127,127), then drain for 1 cycle -> acc sequence 12, 2, 16131. Next cycle: c_out=16131, c_out_valid=1, c_out_ovf=0. Following cycle: acc=0, c_out_valid=0.
3. SIGNED=0. Apply (255,255) twice -> acc=65025, then 130050. Apply (-1,-1) patterns -> no sign extension occurs.
4. ACC_W=16, SATURATE=1. Apply (127,127) x3 -> acc 16129, 32258, then 32767 with ovf set. Drain -> c_out_ovf=1. With SATURATE=0 the third value is -17149 (wrap), ovf still 1.
5. Drain chain. Set acc=7, hold drain 3 cycles, c_in=99 valid in cycle 2, c_in_valid=0 in cycle 3 -> c_out/valid: (7,1), (99,1), (x,0). Drain falls -> state ACCUM.
6. With acc=50, assert clear together with valid (2,3) -> acc=6. Assert clear and drain together -> c_out=6 emitted, acc=0. Assert reset during PASS -> c_out_valid=0 next cycle, state ACCUM.
